// File: rtl/wt_dcache_inval_seq_pkg.sv
// wt_dcache_inval_seq_pkg: shared types for the dcache invalidation sequencer
//   DCACHE_* geometry constants, dcache_inv_req_t queue entry {idx, way},
//   inv_state_e FSM encoding, is_onehot way-mask check.
package wt_dcache_inval_seq_pkg;
  localparam int unsigned DCACHE_NUM_WORDS = 256;
  localparam int unsigned DCACHE_SET_ASSOC = 8;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = $clog2(DCACHE_NUM_WORDS);
  typedef struct packed {
    logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
    logic [DCACHE_SET_ASSOC-1:0]    way;
  } dcache_inv_req_t;
  typedef enum logic [1:0] {IDLE, FLUSH, INV} inv_state_e;
  function automatic logic is_onehot(input logic [DCACHE_SET_ASSOC-1:0] v);
    return (v != '0) && ((v & (v - DCACHE_SET_ASSOC'(1))) == '0);
  endfunction
endpackage

// File: rtl/wt_dcache_inval_seq_fifo.sv
// wt_dcache_inval_seq_fifo: single-line invalidation queue
//   clk_i/rst_i clock and sync reset, flush_i empties the queue,
//   push_i/data_i enqueue, pop_i dequeue, data_o head, next_o entry behind head,
//   full_o/empty_o/one_o occupancy flags (one_o: exactly one entry).
module wt_dcache_inval_seq_fifo #(
  parameter int unsigned Depth = 4,
  parameter type dtype_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   flush_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  dtype_t data_i,
  output dtype_t data_o,
  output dtype_t next_o,
  output logic   full_o,
  output logic   empty_o,
  output logic   one_o
);
  localparam int unsigned AW = $clog2(Depth);
  dtype_t mem_q [Depth];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    rd_d = pop_i ? rd_q + AW'(1) : rd_q;
    wr_d = push_i ? wr_q + AW'(1) : wr_q;
    cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  assign data_o = mem_q[rd_q];
  assign next_o = mem_q[rd_q + AW'(1)];
  assign full_o = cnt_q[AW];
  assign empty_o = cnt_q == '0;
  assign one_o = cnt_q == (AW+1)'(1);
endmodule

// File: rtl/wt_dcache_inval_seq.sv
// wt_dcache_inval_seq: clears dcache valid bits via the shared cacheline write port
//   flush_req_i/flush_ack_o full sweep request and completion pulse,
//   inv_vld_i/inv_rdy_o/inv_idx_i/inv_way_i queued single-line invalidations,
//   wr_cl_vld_o/wr_cl_gnt_i/wr_cl_we_o/wr_cl_idx_o/wr_vld_bits_o registered write port,
//   busy_o activity flag. WT_DCACHE_INIT_FLUSH_EN starts a sweep out of reset.
module wt_dcache_inval_seq
  import wt_dcache_inval_seq_pkg::*;
#(
  parameter int unsigned NumWords  = DCACHE_NUM_WORDS,
  parameter int unsigned SetAssoc  = DCACHE_SET_ASSOC,
  parameter int unsigned IdxWidth  = $clog2(NumWords),
  parameter int unsigned InvQDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_req_i,
  output logic                flush_ack_o,
  input  logic                inv_vld_i,
  output logic                inv_rdy_o,
  input  logic [IdxWidth-1:0] inv_idx_i,
  input  logic [SetAssoc-1:0] inv_way_i,
  output logic                wr_cl_vld_o,
  input  logic                wr_cl_gnt_i,
  output logic [SetAssoc-1:0] wr_cl_we_o,
  output logic [IdxWidth-1:0] wr_cl_idx_o,
  output logic [SetAssoc-1:0] wr_vld_bits_o,
  output logic                busy_o
);
  localparam logic [IdxWidth:0] LastCnt = (IdxWidth+1)'(NumWords - 1);
`ifdef WT_DCACHE_INIT_FLUSH_EN
  localparam logic PendRst = 1'b1;
`else
  localparam logic PendRst = 1'b0;
`endif
  inv_state_e state_q, state_d;
  logic [IdxWidth:0] cnt_q, cnt_d;
  logic pend_q, pend_d, ack_q, ack_d, vld_q, vld_d;
  logic [SetAssoc-1:0] we_q, we_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  dcache_inv_req_t req, head, nxt;
  logic full, empty, one, push, pop, last, stay;
  assign req = '{idx: inv_idx_i, way: inv_way_i};
  // malformed way masks are acked but never stored
  assign push = inv_vld_i && !full && is_onehot(inv_way_i);
  assign pop = (state_q == INV) && wr_cl_gnt_i;
  assign last = (state_q == FLUSH) && wr_cl_gnt_i && (cnt_q == LastCnt);
  // only continue in INV when the next entry is already stored
  assign stay = !one && !pend_q;
  wt_dcache_inval_seq_fifo #(
    .Depth  (InvQDepth),
    .dtype_t(dcache_inv_req_t)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(last),
    .push_i (push),
    .pop_i  (pop),
    .data_i (req),
    .data_o (head),
    .next_o (nxt),
    .full_o (full),
    .empty_o(empty),
    .one_o  (one)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    we_d = we_q;
    idx_d = idx_q;
    ack_d = last;
    pend_d = !last && (pend_q || (flush_req_i && state_q != FLUSH));
    case (state_q)
      IDLE:
        if (pend_q) begin
          state_d = FLUSH;
          cnt_d = '0;
          vld_d = 1'b1;
          we_d = '1;
          idx_d = '0;
        end else if (!empty) begin
          state_d = INV;
          vld_d = 1'b1;
          we_d = head.way;
          idx_d = head.idx;
        end
      FLUSH:
        if (wr_cl_gnt_i) begin
          cnt_d = cnt_q + (IdxWidth+1)'(1);
          state_d = last ? IDLE : FLUSH;
          vld_d = !last;
          we_d = last ? '0 : '1;
          idx_d = last ? '0 : cnt_d[IdxWidth-1:0];
        end
      INV:
        if (wr_cl_gnt_i) begin
          state_d = stay ? INV : IDLE;
          vld_d = stay;
          we_d = stay ? nxt.way : '0;
          idx_d = stay ? nxt.idx : '0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= PendRst;
      ack_q <= 1'b0;
      vld_q <= 1'b0;
      we_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      ack_q <= ack_d;
      vld_q <= vld_d;
      we_q <= we_d;
      idx_q <= idx_d;
    end
  end
  assign flush_ack_o = ack_q;
  assign inv_rdy_o = !full;
  assign wr_cl_vld_o = vld_q;
  assign wr_cl_we_o = we_q;
  assign wr_cl_idx_o = idx_q;
  assign wr_vld_bits_o = '0;
  assign busy_o = (state_q != IDLE) || !empty || (PendRst && pend_q);
endmodule
